// File: rtl/fir_input_sequencer.sv
// fir_input_sequencer
//   Feeds the FIR filter controller. Incoming samples go into a small FIFO.
//   One incoming coefficient is held at a time. The block drives the
//   controller's dr/lc strobes and the shared data_out bus. data_out stays
//   stable until the controller has captured it, and modwait paces every
//   transfer. A full coefficient set (indices 0..NUM_COEFF-1) must be loaded
//   before any sample is released.
//
// Ports
//   clk, n_rst                  clock (rising edge), async active-low reset
//   sample_in/valid/ready       sample stream into the FIFO (ready = not full)
//   coeff_in/valid/ready        coefficient into the holding reg (ready = empty)
//   modwait                     controller busy
//   dr, lc                      data-ready / load-coefficient strobes (Moore)
//   data_out                    value presented to the datapath
//   coeffs_loaded               a complete coefficient set has been delivered
//   fifo_count                  samples currently buffered
module fir_input_sequencer #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 4,
  parameter int NUM_COEFF = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [DATA_W-1:0]          sample_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic [DATA_W-1:0]          coeff_in,
  input  logic                       coeff_valid,
  output logic                       coeff_ready,
  input  logic                       modwait,
  output logic                       dr,
  output logic                       lc,
  output logic [DATA_W-1:0]          data_out,
  output logic                       coeffs_loaded,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_COEFF - 1);

  typedef enum logic [1:0] {IDLE, ISSUE_C, ISSUE_D, BUSY} state_t;

  state_t state_q, state_d;

  logic [DEPTH-1:0][DATA_W-1:0] fifo_mem;
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [CW-1:0]                count;

  logic [DATA_W-1:0]            coeff_q;
  logic                         coeff_full;
  logic [IW-1:0]                coeff_idx;

  logic push, pop, coeff_acc, issue_c, issue_d, c_adv;

  // Ready signals depend only on registered state, so an entry freed in the
  // current cycle cannot be refilled in that same cycle.
  assign sample_ready = (count < FULL_CNT);
  assign coeff_ready  = ~coeff_full;
  assign push         = sample_valid & sample_ready;
  assign coeff_acc    = coeff_valid & ~coeff_full;

  // A held coefficient beats buffered samples.
  assign issue_c = (state_q == IDLE) & ~modwait & coeff_full;
  assign issue_d = (state_q == IDLE) & ~modwait & ~coeff_full & coeffs_loaded &
                   (count != '0);
  assign pop     = issue_d;
  assign c_adv   = (state_q == ISSUE_C) & modwait;

  assign dr         = (state_q == ISSUE_D);
  assign lc         = (state_q == ISSUE_C);
  assign fifo_count = count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue_c)      state_d = ISSUE_C;
               else if (issue_d) state_d = ISSUE_D;
      ISSUE_C: if (modwait)      state_d = BUSY;
      ISSUE_D: if (modwait)      state_d = BUSY;
      BUSY:    if (!modwait)     state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Accepting a new coefficient and freeing the register are mutually
  // exclusive: accepting needs the register empty, freeing needs it full.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      coeff_q    <= '0;
      coeff_full <= 1'b0;
    end else if (coeff_acc) begin
      coeff_q    <= coeff_in;
      coeff_full <= 1'b1;
    end else if (issue_c) begin
      coeff_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)       data_out <= '0;
    else if (issue_c) data_out <= coeff_q;
    else if (issue_d) data_out <= fifo_mem[rd_ptr];
  end

  // The index advances once the controller has taken the coefficient. The
  // set counts as complete on the wrap. Issuing index 0 again starts a reload
  // and blocks samples until that set is complete.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      coeff_idx     <= '0;
      coeffs_loaded <= 1'b0;
    end else if (c_adv) begin
      if (coeff_idx == LAST_IDX) begin
        coeff_idx     <= '0;
        coeffs_loaded <= 1'b1;
      end else begin
        coeff_idx     <= coeff_idx + IW'(1);
      end
    end else if (issue_c && coeff_idx == '0 && coeffs_loaded) begin
      coeffs_loaded <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_input_sequencer.sv
// Bench for fir_input_sequencer. A simple controller model drives modwait.
// Scoreboard queues hold the coefficients and samples in the order the
// sequencer must present them on data_out.
module tb_fir_input_sequencer;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [DW-1:0] sample_in, coeff_in, data_out;
  logic          sample_valid, sample_ready, coeff_valid, coeff_ready;
  logic          modwait, dr, lc, coeffs_loaded;
  logic [$clog2(DEPTH):0] fifo_count;

  fir_input_sequencer #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_COEFF(NC)) dut (
    .clk(clk), .n_rst(n_rst),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .coeff_in(coeff_in), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
    .modwait(modwait), .dr(dr), .lc(lc), .data_out(data_out),
    .coeffs_loaded(coeffs_loaded), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] exp_c[$], exp_s[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // controller model and monitor state
  int       busy_len = 1;
  int       busy_cnt = 0;
  logic     stuck = 1'b0;
  logic     mw = 1'b0;
  logic     dr_q = 1'b0, lc_q = 1'b0, holding = 1'b0;
  logic [DW-1:0] hold_val = '0;
  int       m_idx = 0;
  logic     m_loaded = 1'b0;
  int       n_dr = 0, n_lc = 0;

  assign modwait = mw;

  always @(negedge clk) begin
    if (!n_rst) begin
      mw = 1'b0; busy_cnt = 0; dr_q = 1'b0; lc_q = 1'b0; holding = 1'b0;
      m_idx = 0; m_loaded = 1'b0;
    end else begin
      chk("dr_lc_excl", {31'd0, dr & lc}, 0);
      if (holding) begin
        chk("hold_data", data_out, hold_val);
        if (!mw && !dr && !lc) holding = 1'b0;
      end
      if (dr_q) chk("dr_1cyc", dr, 0);
      if (lc_q) chk("lc_1cyc", lc, 0);
      if (lc && !lc_q) begin
        n_lc++;
        chk("lc_expected", exp_c.size() != 0, 1);
        if (exp_c.size() != 0) chk("lc_data", data_out, exp_c.pop_front());
        if (m_idx == 0 && m_loaded) m_loaded = 1'b0;
        hold_val = data_out; holding = 1'b1;
      end
      if (lc_q && !lc) begin
        m_idx = (m_idx + 1) % NC;
        if (m_idx == 0) m_loaded = 1'b1;
      end
      if (dr && !dr_q) begin
        n_dr++;
        chk("dr_loaded", coeffs_loaded, 1);
        chk("dr_expected", exp_s.size() != 0, 1);
        if (exp_s.size() != 0) chk("dr_data", data_out, exp_s.pop_front());
        hold_val = data_out; holding = 1'b1;
      end
      chk("coeffs_loaded", coeffs_loaded, m_loaded);
      // modwait rises once the strobe is seen and stays high busy_len cycles
      if (stuck) mw = 1'b1;
      else if (!mw && (dr || lc)) begin mw = 1'b1; busy_cnt = busy_len; end
      else if (mw) begin
        if (busy_cnt <= 1) begin mw = 1'b0; busy_cnt = 0; end
        else busy_cnt--;
      end
      dr_q = dr; lc_q = lc;
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic try_sample(input logic [DW-1:0] v, input int lim, output logic acc);
    logic ok;
    sample_in = v; sample_valid = 1'b1; acc = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk); ok = sample_ready;
      @(posedge clk); #1;
      if (ok) begin acc = 1'b1; break; end
    end
    sample_valid = 1'b0;
    if (acc) exp_s.push_back(v);
  endtask

  task automatic send_sample(input logic [DW-1:0] v);
    logic acc;
    try_sample(v, 200, acc);
    chk("sample_accept", acc, 1);
  endtask

  task automatic send_coeff(input logic [DW-1:0] v);
    logic ok, acc;
    coeff_in = v; coeff_valid = 1'b1; acc = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); ok = coeff_ready;
      @(posedge clk); #1;
      if (ok) begin acc = 1'b1; break; end
    end
    coeff_valid = 1'b0;
    if (acc) exp_c.push_back(v);
    chk("coeff_accept", acc, 1);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (exp_c.size() == 0 && exp_s.size() == 0 && !holding && !mw && !dr && !lc) begin
        done = 1'b1; break;
      end
    end
    chk("drain", done, 1);
  endtask

  initial begin
    logic acc;
    n_rst = 1'b0; sample_in = '0; sample_valid = 1'b0; coeff_in = '0; coeff_valid = 1'b0;
    cyc(3);
    chk("rst_dr", dr, 0);
    chk("rst_lc", lc, 0);
    chk("rst_data", data_out, 0);
    chk("rst_loaded", coeffs_loaded, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_sready", sample_ready, 1);
    chk("rst_cready", coeff_ready, 1);
    n_rst = 1'b1;
    cyc(2);

    // sample before coefficients: buffered, not issued
    send_sample(16'h1234);
    cyc(4);
    chk("t2_count", fifo_count, 1);
    chk("t2_no_dr", n_dr, 0);

    // coefficient set with one-cycle busy pulses
    busy_len = 1;
    send_coeff(16'h0001); send_coeff(16'h0002);
    send_coeff(16'h0003); send_coeff(16'h0004);
    chk("t1_no_dr_yet", n_dr, 0);
    drain();
    chk("t1_lc_count", n_lc, 4);
    chk("t1_loaded", coeffs_loaded, 1);
    chk("t2_dr_count", n_dr, 1);

    // long busy; data held, then next issue follows
    busy_len = 10;
    send_sample(16'hA001); send_sample(16'hA002);
    drain();
    chk("t3_dr_count", n_dr, 3);

    // FIFO fills while the controller is stuck busy
    stuck = 1'b1;
    cyc(3);
    send_sample(16'h0100); send_sample(16'h0101);
    send_sample(16'h0102); send_sample(16'h0103);
    chk("t4_count", fifo_count, 4);
    chk("t4_sready", sample_ready, 0);
    try_sample(16'h0BAD, 5, acc);
    chk("t4_5th_rej", acc, 0);
    chk("t4_count2", fifo_count, 4);
    stuck = 1'b0;
    busy_len = 2;
    drain();
    chk("t4_dr_count", n_dr, 7);

    // coefficient and sample together: reload takes priority
    fork
      send_coeff(16'h0011);
      send_sample(16'h5555);
    join
    cyc(10);
    chk("t5_loaded_clr", coeffs_loaded, 0);
    chk("t5_count", fifo_count, 1);
    chk("t5_no_dr", n_dr, 7);
    send_coeff(16'h0012); send_coeff(16'h0013); send_coeff(16'h0014);
    drain();
    chk("t5_dr_count", n_dr, 8);
    chk("t5_loaded", coeffs_loaded, 1);

    // reset while busy with samples queued
    busy_len = 20;
    send_sample(16'hB000); send_sample(16'hB001);
    send_sample(16'hB002); send_sample(16'hB003);
    cyc(3);
    chk("t6_pre_count", fifo_count, 3);
    chk("t6_pre_busy", mw, 1);
    @(posedge clk); #2;
    n_rst = 1'b0;
    #1;
    chk("t6_dr", dr, 0);
    chk("t6_lc", lc, 0);
    chk("t6_count", fifo_count, 0);
    chk("t6_loaded", coeffs_loaded, 0);
    chk("t6_data", data_out, 0);
    chk("t6_sready", sample_ready, 1);
    chk("t6_cready", coeff_ready, 1);
    exp_s.delete(); exp_c.delete();
    cyc(2);
    n_rst = 1'b1;
    cyc(2);

    // after reset the set is gone: samples buffer but do not issue
    busy_len = 1;
    send_sample(16'hC000);
    cyc(5);
    chk("post_count", fifo_count, 1);
    chk("post_no_dr", dr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
